// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: exception codes, default exception vector, and the
// commit-controller state encoding.
package cp0_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC00380;

  // Source of BadVAddr for the selected exception.
  localparam logic [1:0] BADV_NONE  = 2'd0;
  localparam logic [1:0] BADV_PC    = 2'd1;
  localparam logic [1:0] BADV_VADDR = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_COMMIT,
    ST_HOLD
  } state_t;

  // A delay-slot instruction reports the branch as the restart point.
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational priority encoder for commit-stage exception/ERET requests.
// Interrupts always win; other faults are suppressed while EXL is set.
module exc_prio_enc
  import cp0_pkg::*;
(
  input  logic       cm_valid,
  input  logic       cm_adel_if,
  input  logic       cm_ri,
  input  logic       cm_ov,
  input  logic       cm_sys,
  input  logic       cm_bp,
  input  logic       cm_adel_ld,
  input  logic       cm_ades,
  input  logic       cm_eret,
  input  logic       st_ie,
  input  logic       st_exl,
  input  logic [7:0] int_req,
  output logic       take,
  output logic [4:0] code,
  output logic [1:0] badv_sel,
  output logic       is_eret
);

  logic int_pend;
  logic flt_ok;

  assign int_pend = st_ie & ~st_exl & (|int_req);
  assign flt_ok   = ~st_exl;

  always_comb begin
    take     = 1'b0;
    code     = EXC_INT;
    badv_sel = BADV_NONE;
    is_eret  = 1'b0;
    if (cm_valid) begin
      if (int_pend) begin
        take = 1'b1;
        code = EXC_INT;
      end else if (flt_ok && cm_adel_if) begin
        take     = 1'b1;
        code     = EXC_ADEL;
        badv_sel = BADV_PC;
      end else if (flt_ok && cm_ri) begin
        take = 1'b1;
        code = EXC_RI;
      end else if (flt_ok && cm_ov) begin
        take = 1'b1;
        code = EXC_OV;
      end else if (flt_ok && cm_sys) begin
        take = 1'b1;
        code = EXC_SYS;
      end else if (flt_ok && cm_bp) begin
        take = 1'b1;
        code = EXC_BP;
      end else if (flt_ok && cm_adel_ld) begin
        take     = 1'b1;
        code     = EXC_ADEL;
        badv_sel = BADV_VADDR;
      end else if (flt_ok && cm_ades) begin
        take     = 1'b1;
        code     = EXC_ADES;
        badv_sel = BADV_VADDR;
      end else if (cm_eret) begin
        take    = 1'b1;
        is_eret = 1'b1;
      end
    end
  end

endmodule

// File: rtl/exc_commit_ctrl.sv
// Commit-stage exception/ERET controller: issues CP0 update strobes, flush and
// fetch redirect, waiting for any outstanding data-bus transaction first.
module exc_commit_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cm_valid,
  input  logic [31:0] cm_pc,
  input  logic        cm_bd,
  input  logic        cm_adel_if,
  input  logic        cm_ri,
  input  logic        cm_ov,
  input  logic        cm_sys,
  input  logic        cm_bp,
  input  logic        cm_adel_ld,
  input  logic        cm_ades,
  input  logic        cm_eret,
  input  logic [31:0] cm_vaddr,
  input  logic        st_ie,
  input  logic        st_exl,
  input  logic [7:0]  int_req,
  input  logic [31:0] epc_in,
  input  logic        mem_busy,
  output logic        exc_we,
  output logic [4:0]  exc_code,
  output logic [31:0] exc_epc,
  output logic        exc_bd,
  output logic        badv_we,
  output logic [31:0] exc_badv,
  output logic        eret_we,
  output logic        flush,
  output logic        stall,
  output logic        redir_valid,
  output logic [31:0] redir_pc
);

  localparam logic [3:0] HOLD_INIT = 4'(FLUSH_CYCLES);

  state_t      state_reg, state_next;
  logic [3:0]  hold_reg, hold_next;
  logic [4:0]  code_reg;
  logic [31:0] epc_reg;
  logic        bd_reg;
  logic [31:0] badv_reg;
  logic        badv_we_reg;
  logic        eret_reg;

  logic        take;
  logic [4:0]  enc_code;
  logic [1:0]  badv_sel;
  logic        is_eret;
  logic        accept;

  exc_prio_enc u_prio (
    .cm_valid   (cm_valid),
    .cm_adel_if (cm_adel_if),
    .cm_ri      (cm_ri),
    .cm_ov      (cm_ov),
    .cm_sys     (cm_sys),
    .cm_bp      (cm_bp),
    .cm_adel_ld (cm_adel_ld),
    .cm_ades    (cm_ades),
    .cm_eret    (cm_eret),
    .st_ie      (st_ie),
    .st_exl     (st_exl),
    .int_req    (int_req),
    .take       (take),
    .code       (enc_code),
    .badv_sel   (badv_sel),
    .is_eret    (is_eret)
  );

  // Requests are only sampled in IDLE; everything else is ignored.
  assign accept = (state_reg == ST_IDLE) && take;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      hold_reg    <= 4'd0;
      code_reg    <= 5'd0;
      epc_reg     <= 32'd0;
      bd_reg      <= 1'b0;
      badv_reg    <= 32'd0;
      badv_we_reg <= 1'b0;
      eret_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      hold_reg  <= hold_next;
      if (accept) begin
        code_reg    <= enc_code;
        epc_reg     <= epc_of(cm_pc, cm_bd);
        bd_reg      <= cm_bd;
        badv_reg    <= (badv_sel == BADV_PC) ? cm_pc : cm_vaddr;
        badv_we_reg <= (badv_sel != BADV_NONE);
        eret_reg    <= is_eret;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    hold_next   = hold_reg;
    exc_we      = 1'b0;
    exc_code    = 5'd0;
    exc_epc     = 32'd0;
    exc_bd      = 1'b0;
    badv_we     = 1'b0;
    exc_badv    = 32'd0;
    eret_we     = 1'b0;
    flush       = 1'b0;
    stall       = 1'b0;
    redir_valid = 1'b0;
    redir_pc    = 32'd0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) state_next = mem_busy ? ST_DRAIN : ST_COMMIT;
      end
      ST_DRAIN: begin
        stall = 1'b1;
        if (!mem_busy) state_next = ST_COMMIT;
      end
      ST_COMMIT: begin
        flush       = 1'b1;
        redir_valid = 1'b1;
        if (eret_reg) begin
          eret_we  = 1'b1;
          redir_pc = epc_in;
        end else begin
          exc_we   = 1'b1;
          exc_code = code_reg;
          exc_epc  = epc_reg;
          exc_bd   = bd_reg;
          badv_we  = badv_we_reg;
          exc_badv = badv_we_reg ? badv_reg : 32'd0;
          redir_pc = EXC_VECTOR;
        end
        hold_next  = HOLD_INIT;
        state_next = ST_HOLD;
      end
      ST_HOLD: begin
        flush     = 1'b1;
        hold_next = hold_reg - 4'd1;
        if (hold_reg <= 4'd1) begin
          hold_next  = 4'd0;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Self-checking bench for exc_commit_ctrl: table-driven vectors with a strobe
// scoreboard, plus hand sequences for drain and mid-sequence reset.
module tb_exc_commit_ctrl;

  localparam logic [31:0] VEC = 32'hBFC00380;
  localparam int          FLUSH_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cm_valid, cm_bd, cm_adel_if, cm_ri, cm_ov, cm_sys, cm_bp;
  logic        cm_adel_ld, cm_ades, cm_eret, st_ie, st_exl, mem_busy;
  logic [31:0] cm_pc, cm_vaddr, epc_in;
  logic [7:0]  int_req;
  logic        exc_we, exc_bd, badv_we, eret_we, flush, stall, redir_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_epc, exc_badv, redir_pc;

  always #5 clk = ~clk;

  exc_commit_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .rst(rst), .cm_valid(cm_valid), .cm_pc(cm_pc), .cm_bd(cm_bd),
    .cm_adel_if(cm_adel_if), .cm_ri(cm_ri), .cm_ov(cm_ov), .cm_sys(cm_sys),
    .cm_bp(cm_bp), .cm_adel_ld(cm_adel_ld), .cm_ades(cm_ades), .cm_eret(cm_eret),
    .cm_vaddr(cm_vaddr), .st_ie(st_ie), .st_exl(st_exl), .int_req(int_req),
    .epc_in(epc_in), .mem_busy(mem_busy), .exc_we(exc_we), .exc_code(exc_code),
    .exc_epc(exc_epc), .exc_bd(exc_bd), .badv_we(badv_we), .exc_badv(exc_badv),
    .eret_we(eret_we), .flush(flush), .stall(stall), .redir_valid(redir_valid),
    .redir_pc(redir_pc)
  );

  typedef struct {
    logic        is_eret;
    logic [4:0]  code;
    logic [31:0] epc;
    logic        bd;
    logic        badv_we;
    logic [31:0] badv;
    logic [31:0] redir;
  } exp_t;

  // flt bits: {adel_if, ri, ov, sys, bp, adel_ld, ades}
  typedef struct {
    logic [31:0] pc;
    logic        bd;
    logic [6:0]  flt;
    logic        eret;
    logic        valid;
    logic        ie;
    logic        exl;
    logic [7:0]  intr;
    logic [31:0] vaddr;
    logic [31:0] epc_in;
    logic        take;
    exp_t        x;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  int   strobe_cnt = 0;
  int   flush_run = 0;
  exp_t sb[$];
  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] pc, input logic bd, input logic [6:0] flt,
                              input logic eret, input logic valid, input logic ie,
                              input logic exl, input logic [7:0] intr, input logic [31:0] vaddr,
                              input logic [31:0] epcin, input logic take, input logic xeret,
                              input logic [4:0] code, input logic [31:0] xepc,
                              input logic xbadv_we, input logic [31:0] xbadv,
                              input logic [31:0] xredir);
    vec_t v;
    v.pc = pc; v.bd = bd; v.flt = flt; v.eret = eret; v.valid = valid;
    v.ie = ie; v.exl = exl; v.intr = intr; v.vaddr = vaddr; v.epc_in = epcin;
    v.take = take;
    v.x.is_eret = xeret; v.x.code = code; v.x.epc = xepc; v.x.bd = bd;
    v.x.badv_we = xbadv_we; v.x.badv = xbadv; v.x.redir = xredir;
    return v;
  endfunction

  function automatic logic [10:0] outs();
    return {exc_we, badv_we, eret_we, flush, stall, redir_valid, |exc_code, exc_bd,
            |exc_epc, |exc_badv, |redir_pc};
  endfunction

  task automatic clear_cm();
    cm_valid = 0; cm_bd = 0; cm_adel_if = 0; cm_ri = 0; cm_ov = 0; cm_sys = 0;
    cm_bp = 0; cm_adel_ld = 0; cm_ades = 0; cm_eret = 0; int_req = 8'h00;
    cm_pc = 32'h0; cm_vaddr = 32'h0;
  endtask

  task automatic drive(input vec_t v);
    cm_pc = v.pc; cm_bd = v.bd; cm_valid = v.valid; cm_eret = v.eret;
    {cm_adel_if, cm_ri, cm_ov, cm_sys, cm_bp, cm_adel_ld, cm_ades} = v.flt;
    st_ie = v.ie; st_exl = v.exl; int_req = v.intr; cm_vaddr = v.vaddr;
    epc_in = v.epc_in;
    if (v.take) sb.push_back(v.x);
  endtask

  // Monitor: pop the scoreboard on every CP0 strobe, and measure flush length.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst) begin
      flush_run = 0;
    end else begin
      if (flush) flush_run++;
      else if (flush_run != 0) begin
        check("flush_len", 32'(flush_run), 32'(FLUSH_CYCLES + 1));
        flush_run = 0;
      end
      if (exc_we || eret_we) begin
        strobe_cnt++;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_strobe: got exc_we=%0b eret_we=%0b required none",
                   exc_we, eret_we);
        end else begin
          e = sb.pop_front();
          check("eret_we", 32'(eret_we), 32'(e.is_eret));
          check("exc_we", 32'(exc_we), 32'(!e.is_eret));
          check("redir_valid", 32'(redir_valid), 32'd1);
          check("redir_pc", redir_pc, e.redir);
          check("badv_we", 32'(badv_we), 32'(e.badv_we));
          if (!e.is_eret) begin
            check("exc_code", 32'(exc_code), 32'(e.code));
            check("exc_epc", exc_epc, e.epc);
            check("exc_bd", 32'(exc_bd), 32'(e.bd));
            if (e.badv_we) check("exc_badv", exc_badv, e.badv);
          end
          $display("[TB] strobe eret=%0b code=%0d epc=%08h badv_we=%0b badv=%08h redir=%08h",
                   eret_we, exc_code, exc_epc, badv_we, exc_badv, redir_pc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s0;
    vec_t v;

    vecs[0]  = mk(32'hBFC00100, 0, 7'b0010000, 0, 1, 0, 0, 8'h00, 32'h0, 32'h0,
                  1, 0, 5'd12, 32'hBFC00100, 0, 32'h0, VEC);
    vecs[1]  = mk(32'hBFC00204, 1, 7'b0000001, 0, 1, 0, 0, 8'h00, 32'h80001002, 32'h0,
                  1, 0, 5'd5, 32'hBFC00200, 1, 32'h80001002, VEC);
    vecs[2]  = mk(32'hBFC00300, 0, 7'b0001000, 0, 1, 1, 0, 8'h04, 32'h0, 32'h0,
                  1, 0, 5'd0, 32'hBFC00300, 0, 32'h0, VEC);
    vecs[3]  = mk(32'hBFC00300, 0, 7'b0001000, 0, 1, 1, 1, 8'h04, 32'h0, 32'h0,
                  0, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0);
    vecs[4]  = mk(32'hBFC00102, 0, 7'b1100000, 0, 1, 0, 0, 8'h00, 32'h0, 32'h0,
                  1, 0, 5'd4, 32'hBFC00102, 1, 32'hBFC00102, VEC);
    vecs[5]  = mk(32'h80000000, 0, 7'b0010000, 0, 0, 0, 0, 8'h00, 32'h0, 32'h0,
                  0, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0);
    vecs[6]  = mk(32'h80000010, 0, 7'b0001000, 0, 1, 0, 0, 8'h00, 32'h0, 32'h0,
                  1, 0, 5'd8, 32'h80000010, 0, 32'h0, VEC);
    vecs[7]  = mk(32'h80000014, 1, 7'b0000100, 0, 1, 0, 0, 8'h00, 32'h0, 32'h0,
                  1, 0, 5'd9, 32'h80000010, 0, 32'h0, VEC);
    vecs[8]  = mk(32'h80000018, 0, 7'b0000011, 0, 1, 0, 0, 8'h00, 32'h00000003, 32'h0,
                  1, 0, 5'd4, 32'h80000018, 1, 32'h00000003, VEC);
    vecs[9]  = mk(32'h80000020, 0, 7'b0100000, 1, 1, 0, 0, 8'h00, 32'h0, 32'h12345678,
                  1, 0, 5'd10, 32'h80000020, 0, 32'h0, VEC);
    vecs[10] = mk(32'h80000024, 0, 7'b0000000, 1, 1, 0, 0, 8'h00, 32'h0, 32'h80000180,
                  1, 1, 5'd0, 32'h0, 0, 32'h0, 32'h80000180);
    vecs[11] = mk(32'h00000000, 1, 7'b0010000, 0, 1, 0, 0, 8'h00, 32'h0, 32'h0,
                  1, 0, 5'd12, 32'hFFFFFFFC, 0, 32'h0, VEC);
    vecs[12] = mk(32'h80000030, 0, 7'b0000000, 0, 1, 0, 0, 8'hFF, 32'h0, 32'h0,
                  0, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0);
    vecs[13] = mk(32'h80000004, 1, 7'b0000000, 0, 1, 1, 0, 8'h80, 32'h0, 32'h0,
                  1, 0, 5'd0, 32'h80000000, 0, 32'h0, VEC);
    vecs[14] = mk(32'h80000040, 0, 7'b0011100, 0, 1, 0, 0, 8'h00, 32'h0, 32'h0,
                  1, 0, 5'd12, 32'h80000040, 0, 32'h0, VEC);
    vecs[15] = mk(32'h80000044, 0, 7'b0000000, 0, 0, 1, 0, 8'h01, 32'h0, 32'h0,
                  0, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0);
    vecs[16] = mk(32'h80000048, 0, 7'b0000110, 0, 1, 0, 0, 8'h00, 32'h00000001, 32'h0,
                  1, 0, 5'd9, 32'h80000048, 0, 32'h0, VEC);

    clear_cm();
    st_ie = 0; st_exl = 0; epc_in = 32'h0; mem_busy = 0;
    rst = 1;
    repeat (2) @(negedge clk);
    check("reset_outs", 32'(outs()), 32'd0);
    rst = 0;

    foreach (vecs[i]) begin
      v = vecs[i];
      @(negedge clk);
      s0 = strobe_cnt;
      drive(v);
      @(negedge clk);
      clear_cm();
      check("latency", 32'(exc_we | eret_we), 32'(v.take));
      check("stall_nobusy", 32'(stall), 32'd0);
      repeat (5) @(negedge clk);
      check("strobe_count", 32'(strobe_cnt - s0), 32'(v.take));
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("[TB] vec %0d pc=%08h flt=%07b eret=%0b take=%0b done", i, v.pc, v.flt,
               v.eret, v.take);
    end

    // ERET with the data bus busy for 4 cycles; a new fault during drain is ignored.
    st_ie = 0; st_exl = 0;
    @(negedge clk);
    s0 = strobe_cnt;
    v = mk(32'h80000050, 0, 7'b0000000, 1, 1, 0, 0, 8'h00, 32'h0, 32'hBFC00340,
           1, 1, 5'd0, 32'h0, 0, 32'h0, 32'hBFC00340);
    drive(v);
    mem_busy = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      clear_cm();
      if (c > 0) begin
        cm_valid = 1;
        cm_ov = 1;
      end
      check("drain_stall", 32'(stall), 32'd1);
      check("drain_quiet", 32'({flush, exc_we, eret_we, redir_valid}), 32'd0);
    end
    clear_cm();
    mem_busy = 0;
    @(negedge clk);
    check("drain_release", 32'(stall), 32'd0);
    check("drain_commit", 32'(eret_we), 32'd1);
    repeat (5) @(negedge clk);
    check("drain_strobes", 32'(strobe_cnt - s0), 32'd1);
    check("drain_sb", 32'(sb.size()), 32'd0);
    $display("[TB] seq eret_drain done");

    // Reset while in HOLD: sequence aborts, no further strobes.
    @(negedge clk);
    s0 = strobe_cnt;
    v = mk(32'h80000100, 0, 7'b0010000, 0, 1, 0, 0, 8'h00, 32'h0, 32'h0,
           1, 0, 5'd12, 32'h80000100, 0, 32'h0, VEC);
    drive(v);
    @(negedge clk);
    clear_cm();
    @(negedge clk);
    check("hold_flush", 32'(flush), 32'd1);
    rst = 1;
    @(negedge clk);
    check("rst_hold_outs", 32'(outs()), 32'd0);
    rst = 0;
    repeat (4) @(negedge clk);
    check("rst_hold_strobes", 32'(strobe_cnt - s0), 32'd1);
    $display("[TB] seq reset_in_hold done");

    // Reset while in DRAIN: the pending exception is never strobed.
    @(negedge clk);
    s0 = strobe_cnt;
    v = mk(32'h80000200, 0, 7'b0010000, 0, 1, 0, 0, 8'h00, 32'h0, 32'h0,
           0, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0);
    drive(v);
    mem_busy = 1;
    @(negedge clk);
    clear_cm();
    check("pre_rst_stall", 32'(stall), 32'd1);
    rst = 1;
    @(negedge clk);
    check("rst_drain_outs", 32'(outs()), 32'd0);
    rst = 0;
    mem_busy = 0;
    repeat (4) @(negedge clk);
    check("rst_drain_strobes", 32'(strobe_cnt - s0), 32'd0);
    $display("[TB] seq reset_in_drain done");

    // Back in IDLE: a fresh fault is taken with single-cycle latency.
    @(negedge clk);
    s0 = strobe_cnt;
    v = mk(32'h80000300, 1, 7'b0000100, 0, 1, 0, 0, 8'h00, 32'h0, 32'h0,
           1, 0, 5'd9, 32'h800002FC, 0, 32'h0, VEC);
    drive(v);
    @(negedge clk);
    clear_cm();
    check("post_rst_latency", 32'(exc_we), 32'd1);
    repeat (5) @(negedge clk);
    check("post_rst_strobes", 32'(strobe_cnt - s0), 32'd1);
    check("post_rst_sb", 32'(sb.size()), 32'd0);
    $display("[TB] seq post_reset done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
